// File: rtl/shift_dispatch.sv
// shift_dispatch: decodes RV32I shift instructions, queues uops for the shifter and
// registers its result for writeback. Define SHIFT_DISPATCH_STATS_EN for capture counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CTRL_SHIFT_WIDTH
`define CTRL_SHIFT_WIDTH 3
`endif
`ifndef IMMEDIATE_WIDTH
`define IMMEDIATE_WIDTH 32
`endif
`ifndef CTRL_SLL
`define CTRL_SLL  3'd1
`define CTRL_SRL  3'd2
`define CTRL_SRA  3'd3
`define CTRL_SLLI 3'd4
`define CTRL_SRLI 3'd5
`define CTRL_SRAI 3'd6
`endif

module shift_dispatch #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [DATA_WIDTH-1:0]        in_rs1_data,
    input  logic [DATA_WIDTH-1:0]        in_rs2_data,
    output logic                         uop_is_shift,
    output logic [`CTRL_SHIFT_WIDTH-1:0] ctrl_shift,
    output logic [DATA_WIDTH-1:0]        data_src1,
    output logic [DATA_WIDTH-1:0]        data_src2,
    output logic [`IMMEDIATE_WIDTH-1:0]  immediate,
    input  logic [DATA_WIDTH-1:0]        result_shifter,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_result,
    output logic [4:0]                   out_rd,
    output logic                         out_illegal
`ifdef SHIFT_DISPATCH_STATS_EN
    ,
    output logic [31:0]                  stat_shift_cnt,
    output logic [15:0]                  stat_illegal_cnt
`endif
);
    localparam int CW = `CTRL_SHIFT_WIDTH;
    localparam int IW = `IMMEDIATE_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [CW-1:0]         ctrl;
        logic [DATA_WIDTH-1:0] src1;
        logic [DATA_WIDTH-1:0] src2;
        logic [4:0]            shamt;
        logic [4:0]            rd;
        logic                  illegal;
    } uop_t;

    typedef enum logic {EMPTY, FULL} out_state_t;

    uop_t          fifo [DEPTH];
    uop_t          dec_uop;
    uop_t          head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          head_valid, push, pop, capture;
    out_state_t    out_state;

    // rs1/rs2 register indices are resolved upstream; only the data arrives here
    logic unused_rs_idx;
    assign unused_rs_idx = ^in_instr[19:15];

    always_comb begin
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_r, is_i;
        opcode = in_instr[6:0];
        funct3 = in_instr[14:12];
        funct7 = in_instr[31:25];
        is_r   = (opcode == 7'b0110011);
        is_i   = (opcode == 7'b0010011);
        dec_uop         = '0;
        dec_uop.src1    = in_rs1_data;
        dec_uop.src2    = in_rs2_data;
        dec_uop.shamt   = in_instr[24:20];
        dec_uop.rd      = in_instr[11:7];
        // funct7 doubles as imm[11:5] for I-type, so shamt[5] set fails the match
        if (is_r || is_i) begin
            if (funct3 == 3'b001 && funct7 == 7'b0000000)
                dec_uop.ctrl = is_r ? `CTRL_SLL : `CTRL_SLLI;
            else if (funct3 == 3'b101 && funct7 == 7'b0000000)
                dec_uop.ctrl = is_r ? `CTRL_SRL : `CTRL_SRLI;
            else if (funct3 == 3'b101 && funct7 == 7'b0100000)
                dec_uop.ctrl = is_r ? `CTRL_SRA : `CTRL_SRAI;
        end
        dec_uop.illegal = (dec_uop.ctrl == '0);
    end

    assign head       = fifo[rd_ptr];
    assign head_valid = (count != '0);
    assign in_ready   = (count < (PW+1)'(DEPTH));
    assign push       = in_valid && in_ready && !flush;
    assign capture    = head_valid && (out_state == EMPTY || out_ready) && !flush;
    assign pop        = capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= dec_uop;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign uop_is_shift = head_valid && !head.illegal;
    assign ctrl_shift   = head_valid ? head.ctrl : '0;
    assign data_src1    = head_valid ? head.src1 : '0;
    assign data_src2    = head_valid ? head.src2 : '0;
    assign immediate    = head_valid ? {{(IW-5){1'b0}}, head.shamt} : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state   <= EMPTY;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_state   <= EMPTY;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (capture) begin
            out_state   <= FULL;
            out_valid   <= 1'b1;
            out_result  <= head.illegal ? '0 : result_shifter;
            out_rd      <= head.rd;
            out_illegal <= head.illegal;
        end else if (out_state == FULL && out_ready) begin
            out_state <= EMPTY;
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_DISPATCH_STATS_EN
    // counters survive flush so they reflect everything the shifter actually saw
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_shift_cnt   <= '0;
            stat_illegal_cnt <= '0;
        end else if (capture) begin
            if (head.illegal) begin
                if (stat_illegal_cnt != '1) stat_illegal_cnt <= stat_illegal_cnt + 1'b1;
            end else begin
                if (stat_shift_cnt != '1) stat_shift_cnt <= stat_shift_cnt + 1'b1;
            end
        end
    end
`else
    localparam bit STATS_EN = 1'b0;
    logic unused_stats;
    assign unused_stats = STATS_EN;
`endif

endmodule

// File: doc/shift_dispatch.md
Name: shift_dispatch

Overview:
- Issue-side front end for the shifter execution unit.
- Accepts RV32I instruction words plus register-file operands over a valid/ready handshake, then decodes SLL/SLLI/SRL/SRLI/SRA/SRAI.
- Buffers decoded uops in a small FIFO, drives the shifter's uop interface (uop_is_shift, ctrl_shift, data_src1, data_src2, immediate) and registers the returned result for writeback with a valid/ready handshake.

Parameters:
- DEPTH, 2, uop FIFO entries (power of two, >=2)
- DATA_WIDTH, `DATA_WIDTH, operand/result width (32)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discard all queued and output state
- in_valid  in  1  instruction/operand bundle valid
- in_ready  out  1  dispatcher can accept bundle
- in_instr  in  32  RV32I instruction word
- in_rs1_data  in  DATA_WIDTH  rs1 operand
- in_rs2_data  in  DATA_WIDTH  rs2 operand
- uop_is_shift  out  1  to shifter; head entry valid and legal
- ctrl_shift  out  `CTRL_SHIFT_WIDTH  to shifter; `CTRL_SLL..`CTRL_SRAI
- data_src1  out  DATA_WIDTH  to shifter; rs1
- data_src2  out  DATA_WIDTH  to shifter; rs2
- immediate  out  `IMMEDIATE_WIDTH  to shifter; shamt zero-extended
- result_shifter  in  DATA_WIDTH  from shifter, combinational
- out_valid  out  1  writeback bundle valid
- out_ready  in  1  writeback sink accepts
- out_result  out  DATA_WIDTH  shift result
- out_rd  out  5  destination register
- out_illegal  out  1  malformed/non-shift instruction

Behaviour:
- Reset (reset low, async): FIFO empty, rd/wr pointers 0, output register EMPTY, out_valid=0, out_result=0, out_rd=0, out_illegal=0, uop_is_shift=0, ctrl_shift=0, data_src1/2=0, immediate=0.
- Decode at enqueue, from opcode/funct3/funct7:
  - R-type (0110011), funct3=001, funct7=0000000: SLL.
  - R-type (0110011), funct3=101: funct7 0000000 gives SRL; 0100000 gives SRA.
  - I-type (0010011): same funct3/funct7 split gives SLLI/SRLI/SRAI; funct7 is imm[11:5]. shamt = instr[24:20].
  - Any other encoding (including shamt[5] set, i.e. instr[25]=1 for I-type) is accepted, marked illegal, ctrl=0.
- FIFO entry fields: ctrl, src1, src2, shamt, rd=instr[11:7], illegal.
- in_ready = (count < DEPTH). Enqueue when in_valid && in_ready. No same-cycle pop bypass into in_ready.
- Shifter drive: combinational from the FIFO head.
  - uop_is_shift = head_valid && !head_illegal.
  - When the FIFO is empty, all shifter-drive outputs are 0.
- Output register FSM:
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on out_ready with no capture.
  - FULL -> FULL on out_ready with a simultaneous capture.
  - FULL holds while out_ready=0.
- Capture condition: head_valid && (EMPTY || out_ready). Capture loads out_result = illegal ? 0 : result_shifter, plus out_rd and out_illegal, then pops the head.
- Latency: bundle accepted in cycle N appears on out_valid in cycle N+2 when the pipe is idle. Throughput is 1 per cycle with out_ready held high.
- Simultaneous enqueue and pop: count unchanged; pointers wrap modulo DEPTH.
- rd=x0 is still emitted; suppressing the write is the writeback stage's job.
- flush: next cycle FIFO is empty and output is EMPTY. A bundle presented in the flush cycle is dropped. flush wins over all other events.
- out_* hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: SHIFT_DISPATCH_STATS_EN.
- When defined, two extra ports are compiled in:
  - stat_shift_cnt (out, 32): increments on each captured legal uop.
  - stat_illegal_cnt (out, 16): increments on each captured illegal uop.
- Both counters saturate, reset to 0, and are not cleared by flush.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- SLLI x5,x1,4: in_instr=0x00409293, rs1=0x00000001, out_ready=1 -> uop_is_shift=1 and ctrl=`CTRL_SLLI, immediate=4 in cycle N+1; out_valid in N+2 with out_result=0x00000010, out_rd=5, out_illegal=0.
- SRA x7,x2,x3: in_instr=0x403153B3, rs1=0x80000000, rs2=0x00000021 -> out_result=0xC0000000, out_rd=7 (rs2[4:0]=1).
- Illegal SLLI with shamt[5] set: in_instr=0x02009293 -> uop_is_shift=0 while at head; out_illegal=1, out_result=0.
- Backpressure: out_ready=0, push 4 back-to-back -> first captured, next 2 queued, in_ready=0 on the 4th. Raise out_ready -> all 4 emerge in order, one per cycle, values intact.
- Flush/reset mid-operation: FIFO and output full, assert flush -> next cycle out_valid=0, in_ready=1. Repeat with reset low asynchronously -> all outputs 0 immediately.
- With SHIFT_DISPATCH_STATS_EN: 3 legal + 1 illegal drained -> stat_shift_cnt=3, stat_illegal_cnt=1; counters unchanged by flush.
